// File: rtl/glom_pkg.sv
// glom_pkg: shared types, sizes and helpers for the bit-field concatenation
// (glom) sequencer and its combinational field unit.
//   state_t      - sequencer FSM states
//   field_desc_t - one extract descriptor {msb, lsb}
//   field_width  - bits contributed by a descriptor (0 when msb < lsb)
package glom_pkg;
  localparam int DATA_W     = 32;
  localparam int OUT_W      = 32;
  localparam int MAX_FIELDS = 4;
  localparam int IDX_W      = $clog2(MAX_FIELDS);
  localparam int POS_W      = $clog2(DATA_W);
  localparam int WID_W      = $clog2(OUT_W) + 1;

  typedef enum logic [1:0] {IDLE, EXTRACT, DONE} state_t;

  typedef struct packed {
    logic [POS_W-1:0] msb;
    logic [POS_W-1:0] lsb;
  } field_desc_t;

  // Full-word pass-through descriptor, used as the reset value of every slot.
  localparam field_desc_t DESC_DFLT = '{msb: POS_W'(DATA_W-1), lsb: '0};

  function automatic logic [POS_W:0] field_width(field_desc_t d);
    if (d.msb < d.lsb) return '0;
    return {1'b0, d.msb} - {1'b0, d.lsb} + (POS_W+1)'(1);
  endfunction
endpackage

// File: rtl/glom_field_unit.sv
// glom_field_unit: combinational single-field step of the glom datapath.
// Extracts word[msb:lsb] and appends it below the current accumulator.
//   word/desc        - source word and descriptor for this step
//   acc/width        - accumulator and its valid width so far
//   next_acc/width   - updated accumulator (low OUT_W bits kept) and width
//                      (saturated at OUT_W)
//   ovf              - width + w exceeded OUT_W
//   inv              - descriptor had msb < lsb and contributed nothing
module glom_field_unit
  import glom_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  field_desc_t       desc,
  input  logic [OUT_W-1:0]  acc,
  input  logic [WID_W-1:0]  width,
  output logic [OUT_W-1:0]  next_acc,
  output logic [WID_W-1:0]  next_width,
  output logic              ovf,
  output logic              inv
);
  logic [POS_W:0]    w;
  logic [DATA_W:0]   mask;
  logic [DATA_W-1:0] f;
  logic [WID_W:0]    sum;

  always_comb begin
    w    = field_width(desc);
    inv  = desc.msb < desc.lsb;
    // One extra bit so a full-width field (w == DATA_W) still yields all ones.
    mask = ({{DATA_W{1'b0}}, 1'b1} << w) - (DATA_W+1)'(1);
    f    = (word >> desc.lsb) & mask[DATA_W-1:0];
    sum  = {1'b0, width} + (WID_W+1)'(w);
    ovf  = sum > (WID_W+1)'(OUT_W);
    next_width = ovf ? WID_W'(OUT_W) : sum[WID_W-1:0];
    // A shift by OUT_W clears acc, which is exactly the keep-low-bits rule.
    next_acc   = (acc << w) | OUT_W'(f);
  end
endmodule

// File: rtl/glom_sequencer.sv
// glom_sequencer: accepts a word, extracts up to MAX_FIELDS configured
// bit-fields one per clock, packs them MSB-first (field 0 most significant)
// and returns the right-justified result with its width.
//   clk, reset(active-low async)
//   cfg_we/cfg_idx/cfg_msb/cfg_lsb - descriptor slot write (IDLE only)
//   cfg_num_we/cfg_num             - active field count write, clamped
//   in_valid/in_ready/in_data      - input word handshake
//   out_valid/out_ready/out_data/out_width - result handshake
//   busy - in EXTRACT or DONE; err - sticky invalid/overflow flag
module glom_sequencer
  import glom_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [POS_W-1:0]  cfg_msb,
  input  logic [POS_W-1:0]  cfg_lsb,
  input  logic              cfg_num_we,
  input  logic [IDX_W:0]    cfg_num,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [WID_W-1:0]  out_width,
  output logic              busy,
  output logic              err
);
  state_t            state;
  field_desc_t       desc [MAX_FIELDS];
  field_desc_t       snap [MAX_FIELDS];
  logic [IDX_W:0]    num, snap_num;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] word;
  logic [OUT_W-1:0]  acc, nxt_acc;
  logic [WID_W-1:0]  width, nxt_width;
  logic              ovf, inv;

  assign in_ready  = (state == IDLE) && (num != '0);
  assign busy      = (state != IDLE);
  assign out_data  = acc;
  assign out_width = width;

  // The transaction runs from the snapshot so a same-cycle config write
  // at accept cannot leak into it.
  glom_field_unit u_fu (
    .word       (word),
    .desc       (snap[idx]),
    .acc        (acc),
    .width      (width),
    .next_acc   (nxt_acc),
    .next_width (nxt_width),
    .ovf        (ovf),
    .inv        (inv)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      width     <= '0;
      idx       <= '0;
      word      <= '0;
      num       <= (IDX_W+1)'(1);
      snap_num  <= (IDX_W+1)'(1);
      for (int i = 0; i < MAX_FIELDS; i++) begin
        desc[i] <= DESC_DFLT;
        snap[i] <= DESC_DFLT;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) desc[cfg_idx] <= '{msb: cfg_msb, lsb: cfg_lsb};
          if (cfg_num_we)
            num <= (cfg_num > (IDX_W+1)'(MAX_FIELDS)) ? (IDX_W+1)'(MAX_FIELDS) : cfg_num;
          if (in_valid && in_ready) begin
            word     <= in_data;
            acc      <= '0;
            width    <= '0;
            idx      <= '0;
            err      <= 1'b0;
            snap     <= desc;
            snap_num <= num;
            state    <= EXTRACT;
          end
        end
        EXTRACT: begin
          acc   <= nxt_acc;
          width <= nxt_width;
          err   <= err | ovf | inv;
          idx   <= idx + IDX_W'(1);
          if ({1'b0, idx} == snap_num - (IDX_W+1)'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
